// File: rtl/mem_stage_pkg.sv
// Shared memory-op codes, widths and decode helpers for the MEM stage.
package mem_stage_pkg;

  typedef logic [3:0] memOp_t;

  localparam memOp_t MEM_NOP = 4'd0;
  localparam memOp_t MEM_LB  = 4'd1;
  localparam memOp_t MEM_LH  = 4'd2;
  localparam memOp_t MEM_LW  = 4'd3;
  localparam memOp_t MEM_LBU = 4'd4;
  localparam memOp_t MEM_LHU = 4'd5;
  localparam memOp_t MEM_SB  = 4'd6;
  localparam memOp_t MEM_SH  = 4'd7;
  localparam memOp_t MEM_SW  = 4'd8;

  localparam logic [31:0] ZERO32 = 32'h0000_0000;

  function automatic logic isLoad(input memOp_t op);
    return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
           (op == MEM_LBU) || (op == MEM_LHU);
  endfunction

  function automatic logic isStore(input memOp_t op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Index of the final byte of an access (access size minus one).
  function automatic logic [1:0] lastByteIdx(input memOp_t op);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return 2'd1;
      MEM_LW, MEM_SW:          return 2'd3;
      default:                 return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load formatter: picks byte/half/word from the assembled
// little-endian bytes and sign- or zero-extends it to 32 bits.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [31:0] i_bytes,
  output logic [31:0] o_data
);

  always_comb begin
    o_data = ZERO32;
    case (i_op)
      MEM_LB:  o_data = {{24{i_bytes[7]}}, i_bytes[7:0]};
      MEM_LBU: o_data = {24'h000000, i_bytes[7:0]};
      MEM_LH:  o_data = {{16{i_bytes[15]}}, i_bytes[15:0]};
      MEM_LHU: o_data = {16'h0000, i_bytes[15:0]};
      MEM_LW:  o_data = i_bytes;
      default: o_data = ZERO32;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU results pass through, loads/stores run byte-serially
// over an arbitrated 8-bit port. Optional misaligned trap: MEM_MISALIGN_TRAP_EN.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [3:0]  memOp_in,
  input  logic [31:0] memAddr_in,
  input  logic [31:0] memWData_in,
  input  logic        rdE_in,
  input  logic [4:0]  rdIdx_in,
  input  logic [31:0] rdData_in,
  output logic        rdE_out,
  output logic [4:0]  rdIdx_out,
  output logic [31:0] rdData_out,
  output logic        stall_req_out,
  output logic        mem_req_out,
  input  logic        mem_gnt_in,
  output logic        mem_wr_out,
  output logic [31:0] mem_addr_out,
  output logic [7:0]  mem_wdata_out,
  input  logic [7:0]  mem_rdata_in,
  output logic        misalign_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic             r_pend;
  logic [1:0]       r_pendIdx;
  logic [3:0][7:0]  r_bytes;

  logic             w_isLoad;
  logic             w_isStore;
  logic             w_isMem;
  logic [1:0]       w_lastIdx;
  logic             w_trap;
  logic             w_req;
  logic             w_fire;
  logic [3:0][7:0]  w_loadBytes;
  logic [31:0]      w_loadData;

  assign w_isLoad  = isLoad(memOp_in);
  assign w_isStore = isStore(memOp_in);
  assign w_isMem   = w_isLoad || w_isStore;
  assign w_lastIdx = lastByteIdx(memOp_in);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_isMem && (r_state == S_IDLE) &&
                  (((w_lastIdx == 2'd1) && memAddr_in[0]) ||
                   ((w_lastIdx == 2'd3) && (memAddr_in[1:0] != 2'b00)));
`else
  assign w_trap = 1'b0;
`endif

  assign w_req  = w_isMem && (r_state != S_DONE) && !w_trap;
  assign w_fire = w_req && mem_gnt_in;

  // The final byte of a load is consumed straight off the port in DONE.
  always_comb begin
    w_loadBytes            = r_bytes;
    w_loadBytes[w_lastIdx] = mem_rdata_in;
  end

  mem_load_ext u_loadExt (
    .i_op    (memOp_in),
    .i_bytes (w_loadBytes),
    .o_data  (w_loadData)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_cnt     <= 2'd0;
      r_pend    <= 1'b0;
      r_pendIdx <= 2'd0;
      r_bytes   <= '0;
    end else begin
      r_pend <= w_fire && w_isLoad;
      if (w_fire) r_pendIdx <= r_cnt;
      if (r_pend && (r_pendIdx != w_lastIdx)) r_bytes[r_pendIdx] <= mem_rdata_in;
      case (r_state)
        S_IDLE, S_XFER: begin
          if (w_trap) begin
            r_state <= S_DONE;
            r_cnt   <= 2'd0;
          end else if (w_fire) begin
            if (r_cnt == w_lastIdx) begin
              r_state <= S_DONE;
              r_cnt   <= 2'd0;
            end else begin
              r_state <= S_XFER;
              r_cnt   <= r_cnt + 2'd1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  // Every output is held low while reset is asserted.
  always_comb begin
    rdE_out       = 1'b0;
    rdIdx_out     = 5'd0;
    rdData_out    = ZERO32;
    stall_req_out = 1'b0;
    mem_req_out   = 1'b0;
    mem_wr_out    = 1'b0;
    mem_addr_out  = ZERO32;
    mem_wdata_out = 8'h00;
    misalign_out  = 1'b0;
    if (rst_in) begin
      rdE_out       = rdE_in && !w_trap;
      rdIdx_out     = rdIdx_in;
      rdData_out    = ((r_state == S_DONE) && w_isLoad) ? w_loadData : rdData_in;
      stall_req_out = w_req;
      mem_req_out   = w_req;
      mem_wr_out    = w_isStore;
      mem_addr_out  = memAddr_in + {30'd0, r_cnt};
      mem_wdata_out = memWData_in[{r_cnt, 3'b000} +: 8];
      misalign_out  = w_trap;
    end
  end

endmodule
